dual_port_ram_strb_sync_rd: RTL and testbench



---
 rtl/dual_port_ram_strb_sync_rd_pkg.sv | 22 ++
 rtl/dual_port_ram_strb_sync_rd_byte_lane.sv | 39 +++
 rtl/dual_port_ram_strb_sync_rd.sv | 142 ++++++++++++++
 tb/tb_dual_port_ram_strb_sync_rd.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/dual_port_ram_strb_sync_rd_pkg.sv
// Shared definitions for the byte-strobed dual-port RAM: sequencer states,
// address-offset width and read-latency legality.
package dual_port_ram_strb_sync_rd_pkg;

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_t;

    localparam int RD_LATENCY_MIN = 1;
    localparam int RD_LATENCY_MAX = 2;

    // Number of byte-offset bits below the word address.
    function automatic int addr_nc_bits(input int width);
        return $clog2(width / 8);
    endfunction

    function automatic bit rd_latency_ok(input int latency);
        return (latency >= RD_LATENCY_MIN) && (latency <= RD_LATENCY_MAX);
    endfunction

endpackage

// File: rtl/dual_port_ram_strb_sync_rd_byte_lane.sv
// One 8-bit simple dual-port lane: init/write port with init priority and a
// registered read port that holds its value between reads.
module dual_port_ram_byte_lane #(
    parameter int AWIDTH = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init_en,
    input  logic [AWIDTH-1:0] init_addr,
    input  logic [7:0]        init_data,
    input  logic              wr_en,
    input  logic [AWIDTH-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              rd_en,
    input  logic [AWIDTH-1:0] rd_addr,
    output logic [7:0]        rd_data
);

    logic [7:0] mem [2**AWIDTH];

    // NOTE: the array has no reset so it maps onto block RAM; the init sweep fills it instead.
    always_ff @(posedge clk) begin
        if (init_en) begin
            mem[init_addr] <= init_data;
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // A same-edge write is not seen here (old data); the top level forwards it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/dual_port_ram_strb_sync_rd.sv
// Byte-strobed dual-port RAM with write-first collision forwarding, a 1- or
// 2-cycle read pipeline and a post-reset fill sequencer.
module dual_port_ram_strb_sync_rd
    import dual_port_ram_strb_sync_rd_pkg::*;
#(
    parameter int         FIFO_AWIDTH = 9,
    parameter int         FIFO_WIDTH  = 32,
    parameter int         RD_LATENCY  = 1,
    parameter logic [7:0] INIT_BYTE   = 8'hFF,
    localparam int        ADDR_NC_BITS = addr_nc_bits(FIFO_WIDTH)
) (
    input  logic                                HCLK,
    input  logic                                HRESETn,
    output logic                                initBusy,
    input  logic [FIFO_AWIDTH+ADDR_NC_BITS-1:0] fifoWrAddr,
    input  logic                                fifoWrite,
    input  logic [FIFO_WIDTH/8-1:0]             fifoWrStrb,
    input  logic [FIFO_WIDTH-1:0]               fifoWrData,
    input  logic [FIFO_AWIDTH+ADDR_NC_BITS-1:0] fifoRdAddr,
    input  logic                                fifoRead,
    output logic [FIFO_WIDTH-1:0]               fifoRdData,
    output logic                                fifoRdValid
);

    localparam int NBYTES = FIFO_WIDTH / 8;
    localparam int DEPTH  = 2**FIFO_AWIDTH;
    localparam logic [FIFO_AWIDTH:0] CNT_LAST = (FIFO_AWIDTH+1)'(DEPTH - 1);
    localparam logic [FIFO_AWIDTH:0] CNT_ONE  = (FIFO_AWIDTH+1)'(1);

    if (!rd_latency_ok(RD_LATENCY)) begin : g_bad_latency
        $error("RD_LATENCY must be 1 or 2");
    end

    if (ADDR_NC_BITS > 0) begin : g_nc_bits
        // Byte-offset bits are dropped by design.
        logic unused_nc_bits;
        assign unused_nc_bits = ^{fifoWrAddr[ADDR_NC_BITS-1:0], fifoRdAddr[ADDR_NC_BITS-1:0]};
    end

    state_t                 state;
    logic [FIFO_AWIDTH:0]   init_cnt;
    logic                   init_en;
    logic                   wr_go;
    logic                   rd_go;
    logic                   collide;
    logic [FIFO_AWIDTH-1:0] wr_word;
    logic [FIFO_AWIDTH-1:0] rd_word;
    logic [FIFO_WIDTH-1:0]  lane_rd;
    logic [NBYTES-1:0]      fwd_mask;
    logic [FIFO_WIDTH-1:0]  fwd_data;
    logic [FIFO_WIDTH-1:0]  stage1_data;
    logic                   valid1;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state    <= ST_INIT;
            init_cnt <= '0;
            initBusy <= 1'b1;
        end else if (state == ST_INIT) begin
            init_cnt <= init_cnt + CNT_ONE;
            if (init_cnt == CNT_LAST) begin
                state    <= ST_READY;
                initBusy <= 1'b0;
            end
        end
    end

    assign init_en = HRESETn && (state == ST_INIT);
    assign wr_go   = HRESETn && !initBusy && fifoWrite;
    assign rd_go   = HRESETn && !initBusy && fifoRead;
    assign wr_word = fifoWrAddr[FIFO_AWIDTH+ADDR_NC_BITS-1:ADDR_NC_BITS];
    assign rd_word = fifoRdAddr[FIFO_AWIDTH+ADDR_NC_BITS-1:ADDR_NC_BITS];
    assign collide = wr_go && rd_go && (wr_word == rd_word);

    for (genvar i = 0; i < NBYTES; i++) begin : g_lane
        dual_port_ram_byte_lane #(
            .AWIDTH(FIFO_AWIDTH)
        ) u_lane (
            .clk      (HCLK),
            .rst_n    (HRESETn),
            .init_en  (init_en),
            .init_addr(init_cnt[FIFO_AWIDTH-1:0]),
            .init_data(INIT_BYTE),
            .wr_en    (wr_go && fifoWrStrb[i]),
            .wr_addr  (wr_word),
            .wr_data  (fifoWrData[8*i +: 8]),
            .rd_en    (rd_go),
            .rd_addr  (rd_word),
            .rd_data  (lane_rd[8*i +: 8])
        );
    end

    // Remember which bytes of the issued read were overwritten on the same edge.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            fwd_mask <= '0;
            fwd_data <= '0;
            valid1   <= 1'b0;
        end else begin
            valid1 <= rd_go;
            if (rd_go) begin
                fwd_mask <= collide ? fifoWrStrb : '0;
                fwd_data <= fifoWrData;
            end
        end
    end

    always_comb begin
        // NOTE: default assignment first so no path leaves stage1_data unassigned (no latch).
        stage1_data = lane_rd;
        for (int i = 0; i < NBYTES; i++) begin
            if (fwd_mask[i]) begin
                stage1_data[8*i +: 8] = fwd_data[8*i +: 8];
            end
        end
    end

    if (RD_LATENCY == 2) begin : g_stage2
        logic [FIFO_WIDTH-1:0] data_q;
        logic                  valid_q;

        always_ff @(posedge HCLK) begin
            if (!HRESETn) begin
                data_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                valid_q <= valid1;
                if (valid1) begin
                    data_q <= stage1_data;
                end
            end
        end

        assign fifoRdData  = data_q;
        assign fifoRdValid = valid_q;
    end else begin : g_stage1
        assign fifoRdData  = stage1_data;
        assign fifoRdValid = valid1;
    end

endmodule

// File: tb/tb_dual_port_ram_strb_sync_rd.sv
// Drives a 1-cycle and a 2-cycle instance with shared stimulus and compares
// both against a word-array reference model of the RAM behaviour.
module tb_dual_port_ram_strb_sync_rd;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [3:0]  wr_strb;
    logic [31:0] wr_data;
    logic        rd_en;
    logic [5:0]  rd_addr;

    logic        busy1, busy2;
    logic        rvalid1, rvalid2;
    logic [31:0] rdata1, rdata2;

    int errors = 0;
    int checks = 0;

    // Reference model state.
    logic [31:0] m_mem [16];
    bit          m_busy;
    int          m_cnt;
    bit          m_v1, m_v2, m_pend;
    logic [31:0] m_d1, m_d2, m_pend_d;

    always #5 clk = ~clk;

    dual_port_ram_strb_sync_rd #(
        .FIFO_AWIDTH(4), .FIFO_WIDTH(32), .RD_LATENCY(1), .INIT_BYTE(8'hFF)
    ) u_dut_l1 (
        .HCLK(clk), .HRESETn(rst_n), .initBusy(busy1),
        .fifoWrAddr(wr_addr), .fifoWrite(wr_en), .fifoWrStrb(wr_strb), .fifoWrData(wr_data),
        .fifoRdAddr(rd_addr), .fifoRead(rd_en), .fifoRdData(rdata1), .fifoRdValid(rvalid1)
    );

    dual_port_ram_strb_sync_rd #(
        .FIFO_AWIDTH(4), .FIFO_WIDTH(32), .RD_LATENCY(2), .INIT_BYTE(8'hFF)
    ) u_dut_l2 (
        .HCLK(clk), .HRESETn(rst_n), .initBusy(busy2),
        .fifoWrAddr(wr_addr), .fifoWrite(wr_en), .fifoWrStrb(wr_strb), .fifoWrData(wr_data),
        .fifoRdAddr(rd_addr), .fifoRead(rd_en), .fifoRdData(rdata2), .fifoRdValid(rvalid2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) r[8*i +: 8] = nw[8*i +: 8];
        end
        return r;
    endfunction

    // Advance the model by one edge from the current inputs, clock the DUTs, compare.
    task automatic step();
        bit          issue;
        logic [31:0] rv;
        issue = 1'b0;
        rv    = '0;
        if (!rst_n) begin
            m_busy = 1'b1; m_cnt = 0;
            m_v1 = 1'b0; m_v2 = 1'b0; m_pend = 1'b0;
            m_d1 = '0; m_d2 = '0;
        end else begin
            if (m_busy) begin
                m_mem[m_cnt] = 32'hFFFFFFFF;
                m_cnt++;
                if (m_cnt == 16) m_busy = 1'b0;
            end else begin
                // Write-first: apply the write, then the same-edge read sees it.
                if (wr_en) m_mem[wr_addr[5:2]] = merge(m_mem[wr_addr[5:2]], wr_data, wr_strb);
                if (rd_en) begin
                    issue = 1'b1;
                    rv    = m_mem[rd_addr[5:2]];
                end
            end
            m_v2 = m_pend;
            if (m_pend) m_d2 = m_pend_d;
            m_pend   = issue;
            m_pend_d = rv;
            m_v1     = issue;
            if (issue) m_d1 = rv;
        end
        @(posedge clk);
        #1;
        check("busy_l1", {31'b0, busy1}, {31'b0, m_busy});
        check("busy_l2", {31'b0, busy2}, {31'b0, m_busy});
        check("valid_l1", {31'b0, rvalid1}, {31'b0, m_v1});
        check("data_l1", rdata1, m_d1);
        check("valid_l2", {31'b0, rvalid2}, {31'b0, m_v2});
        check("data_l2", rdata2, m_d2);
    endtask

    task automatic idle();
        wr_en = 1'b0; rd_en = 1'b0; wr_strb = '0; wr_data = '0; wr_addr = '0; rd_addr = '0;
    endtask

    // Hold reset released until initBusy drops; returns how many cycles it stayed high.
    task automatic wait_init(output int busy_cycles, output bit saw_valid);
        busy_cycles = 0;
        saw_valid   = 1'b0;
        while (busy1 && busy_cycles < 100) begin
            busy_cycles++;
            step();
            saw_valid = saw_valid | rvalid1 | rvalid2;
        end
    endtask

    initial begin
        int  busy_cycles;
        bit  saw_valid;

        for (int i = 0; i < 16; i++) m_mem[i] = '0;
        idle();
        rst_n = 1'b0;
        repeat (3) step();
        check("reset_busy", {31'b0, busy1}, 32'd1);
        check("reset_rdata", rdata1, 32'h0);

        // Release reset with accesses held high for the whole sweep; all must be ignored.
        rst_n = 1'b1;
        wr_en = 1'b1; wr_strb = 4'hF; wr_data = 32'h12345678; wr_addr = 6'h14;
        rd_en = 1'b1; rd_addr = 6'h14;
        wait_init(busy_cycles, saw_valid);
        idle();
        check("init_busy_cycles", busy_cycles, 32'd16);
        check("init_no_valid", {31'b0, saw_valid}, 32'd0);

        // Read back every word, with random byte-offset bits that must be dropped.
        for (int w = 0; w < 16; w++) begin
            rd_en   = 1'b1;
            rd_addr = {4'(w), 2'($urandom_range(0, 3))};
            step();
            check("fill_word", rdata1, 32'hFFFFFFFF);
        end
        idle();
        step();

        // Partial strobe.
        wr_en = 1'b1; wr_addr = 6'h08; wr_data = 32'h11223344; wr_strb = 4'b0101;
        step();
        idle();
        rd_en = 1'b1; rd_addr = 6'h08;
        step();
        idle();
        check("strobe_valid", {31'b0, rvalid1}, 32'd1);
        check("strobe_data", rdata1, 32'hFF22FF44);

        // Same-cycle collision with partial strobe.
        wr_en = 1'b1; wr_addr = 6'h0C; wr_data = 32'hAABBCCDD; wr_strb = 4'hF;
        step();
        wr_data = 32'h01020304; wr_strb = 4'b1100;
        rd_en = 1'b1; rd_addr = 6'h0C;
        step();
        idle();
        check("collide_data", rdata1, 32'h0102CCDD);
        step();
        check("collide_hold", rdata1, 32'h0102CCDD);

        // Two-cycle streaming: words 0,1,2, then overwrite word 1 after its read.
        rd_en = 1'b1; rd_addr = 6'h00;
        step();
        check("stream_v_a", {31'b0, rvalid2}, 32'd0);
        rd_addr = 6'h04;
        step();
        check("stream_v_b", {31'b0, rvalid2}, 32'd1);
        check("stream_d_w0", rdata2, 32'hFFFFFFFF);
        rd_addr = 6'h08;
        wr_en = 1'b1; wr_addr = 6'h04; wr_data = 32'hDEADBEEF; wr_strb = 4'hF;
        step();
        idle();
        check("stream_v_c", {31'b0, rvalid2}, 32'd1);
        check("stream_d_w1", rdata2, 32'hFFFFFFFF);
        step();
        check("stream_v_d", {31'b0, rvalid2}, 32'd1);
        check("stream_d_w2", rdata2, 32'hFF22FF44);
        step();
        check("stream_v_e", {31'b0, rvalid2}, 32'd0);

        // Randomized traffic with frequent same-word collisions.
        for (int n = 0; n < 300; n++) begin
            wr_en   = 1'($urandom_range(0, 1));
            wr_addr = 6'($urandom_range(0, 63));
            wr_strb = 4'($urandom_range(0, 15));
            wr_data = $urandom;
            rd_en   = 1'($urandom_range(0, 1));
            rd_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 6'($urandom_range(0, 63));
            step();
        end

        // Reset while a two-cycle read is in flight: it must be discarded.
        idle();
        rd_en = 1'b1; rd_addr = 6'h10;
        step();
        idle();
        rst_n = 1'b0;
        step();
        check("midread_v_l2", {31'b0, rvalid2}, 32'd0);

        // Reset again at sweep count 7; the sweep restarts from word 0.
        rst_n = 1'b1;
        repeat (7) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        wait_init(busy_cycles, saw_valid);
        check("reinit_busy_cycles", busy_cycles, 32'd16);
        for (int w = 0; w < 16; w++) begin
            rd_en   = 1'b1;
            rd_addr = {4'(w), 2'b00};
            step();
            check("refill_word", rdata1, 32'hFFFFFFFF);
        end
        idle();
        repeat (2) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
